// File: rtl/store_trace_fifo.sv
// Store trace FIFO: records every core data-memory store with a sequence tag
// for a debug consumer; never back-pressures the core, drops and counts when full.
module store_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     memwrite,
    input  logic [ADDR_W-1:0]        dataadr,
    input  logic [DATA_W-1:0]        writedata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [SEQ_W-1:0]         overflow_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [SEQ_W-1:0]  mem_seq  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [SEQ_W-1:0]  seq;
    logic              push;
    logic              pop;

    assign out_valid = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop       = out_valid && out_ready;
    // A pop frees the slot this cycle, so a full FIFO can still accept a store.
    assign push      = memwrite && (!full || pop);

    assign out_addr  = mem_addr[rd_ptr];
    assign out_data  = mem_data[rd_ptr];
    assign out_seq   = mem_seq[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            seq          <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            // Tag advances even on drops so the consumer can see gaps.
            if (memwrite)
                seq <= seq + SEQ_W'(1);
            if (memwrite && !push && (overflow_cnt != '1))
                overflow_cnt <= overflow_cnt + SEQ_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear && push) begin
            mem_addr[wr_ptr] <= dataadr;
            mem_data[wr_ptr] <= writedata;
            mem_seq[wr_ptr]  <= seq;
        end
    end

endmodule

// File: tb/tb_store_trace_fifo.sv
// Bench for store_trace_fifo: table-driven vectors plus hand sequences, with a
// queue scoreboard checking every head entry the consumer sees.
module tb_store_trace_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [15:0] out_seq;
    logic [4:0]  count;
    logic        full;
    logic [15:0] overflow_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] seq;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t        sb[$];
    logic [15:0] m_seq = '0;
    logic [15:0] m_ovf = '0;

    typedef struct {
        logic        r;
        logic        c;
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
        logic [4:0]  exp_cnt;
        logic        exp_valid;
        logic [15:0] exp_ovf;
        logic        chk_head;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [15:0] exp_seq;
    } vec_t;

    vec_t vecs[$];

    store_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .SEQ_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .out_seq(out_seq), .count(count), .full(full), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One cycle: drive, check head against scoreboard, update model, clock, check state.
    task automatic step(input logic r, input logic c, input logic mw,
                        input logic [31:0] a, input logic [31:0] d, input logic rdy);
        ent_t e;
        logic popping;
        rst_n = r; clear = c; memwrite = mw; dataadr = a; writedata = d; out_ready = rdy;
        #1;
        if (!r || c) begin
            sb.delete();
            m_seq = '0;
            m_ovf = '0;
        end else begin
            check("pre_valid", out_valid, sb.size() != 0);
            popping = (sb.size() != 0) && rdy;
            if (sb.size() != 0) begin
                check("head_addr", out_addr, sb[0].addr);
                check("head_data", out_data, sb[0].data);
                check("head_seq", out_seq, sb[0].seq);
            end
            if (popping) void'(sb.pop_front());
            if (mw) begin
                if (sb.size() < DEPTH) begin
                    e.seq = m_seq; e.addr = a; e.data = d;
                    sb.push_back(e);
                end else if (m_ovf != 16'hffff) begin
                    m_ovf = m_ovf + 16'd1;
                end
                m_seq = m_seq + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        check("count", count, sb.size());
        check("valid", out_valid, sb.size() != 0);
        check("full", full, sb.size() == DEPTH);
        check("overflow_cnt", overflow_cnt, m_ovf);
    endtask

    function automatic vec_t mk(logic r, logic c, logic mw, logic [31:0] a, logic [31:0] d,
                                logic rdy, logic [4:0] ec, logic ev, logic [15:0] eo,
                                logic ch, logic [31:0] ea, logic [31:0] ed, logic [15:0] es);
        vec_t v;
        v.r = r; v.c = c; v.mw = mw; v.a = a; v.d = d; v.rdy = rdy;
        v.exp_cnt = ec; v.exp_valid = ev; v.exp_ovf = eo;
        v.chk_head = ch; v.exp_addr = ea; v.exp_data = ed; v.exp_seq = es;
        return v;
    endfunction

    initial begin
        // Reset held 3 cycles with memwrite active, then release.
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 1, 32'h55, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Single store, shown next cycle, then drained.
        vecs.push_back(mk(1, 0, 1, 200, 1, 0, 1, 1, 0, 1, 200, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 200, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // Clear, then 8 ordered stores with the consumer starting one cycle later.
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 200, 32'h100, 0, 1, 1, 0, 1, 200, 32'h100, 0));
        for (int i = 1; i < 8; i++)
            vecs.push_back(mk(1, 0, 1, 200 + 4 * i, 32'h100 + i, 1, 1, 1, 0,
                              1, 200 + 4 * i, 32'h100 + i, 16'(i)));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].c, vecs[i].mw, vecs[i].a, vecs[i].d, vecs[i].rdy);
            check($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
            check($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_ovf", i), overflow_cnt, vecs[i].exp_ovf);
            if (vecs[i].chk_head) begin
                check($sformatf("vec%0d_addr", i), out_addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
                check($sformatf("vec%0d_seq", i), out_seq, vecs[i].exp_seq);
            end
        end

        // Overflow: 18 stores into a stalled FIFO.
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++)
            step(1, 0, 1, 32'h1000 + 4 * i, 32'hA000 + i, 0);
        check("ovf_full", full, 1'b1);
        check("ovf_count", count, 5'd16);
        check("ovf_cnt2", overflow_cnt, 16'd2);
        check("ovf_head_seq", out_seq, 16'd0);

        // Full with simultaneous store and pop: store #19 accepted with seq 18.
        step(1, 0, 1, 32'hBEEF0, 32'hCAFE, 1);
        check("fullpp_count", count, 5'd16);
        check("fullpp_ovf", overflow_cnt, 16'd2);
        check("fullpp_head_seq", out_seq, 16'd1);
        for (int i = 0; i < 15; i++)
            step(1, 0, 0, 0, 0, 1);
        check("tail_seq", out_seq, 16'd18);
        check("tail_addr", out_addr, 32'hBEEF0);
        check("tail_data", out_data, 32'hCAFE);
        step(1, 0, 0, 0, 0, 1);
        check("drained_count", count, 5'd0);

        // Mid-operation clear with a store pending on the same edge.
        for (int i = 0; i < 5; i++)
            step(1, 0, 1, 32'h300 + i, 32'h700 + i, 0);
        check("pre_clear_count", count, 5'd5);
        step(1, 1, 1, 32'h999, 32'h999, 0);
        check("clear_count", count, 5'd0);
        check("clear_valid", out_valid, 1'b0);
        check("clear_ovf", overflow_cnt, 16'd0);
        step(1, 0, 1, 32'h444, 32'h555, 0);
        check("post_clear_seq", out_seq, 16'd0);
        check("post_clear_addr", out_addr, 32'h444);

        // Empty + store + ready: no pop this cycle, entry visible next cycle.
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h888, 32'h777, 1);
        check("empty_rdy_count", count, 5'd1);
        check("empty_rdy_addr", out_addr, 32'h888);
        step(1, 0, 0, 0, 0, 1);

        // Reset has priority over clear and pending stores.
        step(1, 0, 1, 32'h1, 32'h2, 0);
        step(0, 1, 1, 32'h3, 32'h4, 1);
        check("rst_count", count, 5'd0);
        check("rst_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
